// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// cdb_entry_t is the payload carried from an execution unit to the CDB.
package cdb_pkg;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  branch;
        logic                  branch_taken;
    } cdb_entry_t;

    typedef struct packed {
        logic       valid;
        cdb_entry_t entry;
    } cdb_submit_data_t;

    // Modular add for channel indices; both operands are already below n.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/cdb_arbiter_n_if.sv
// Submit-side and broadcast-side signals of the CDB arbiter.
// Submit handshake: a channel push happens on a rising edge where ch_valid[k] and
// ch_ready[k] are both 1; ch_ready never depends on ch_valid, and a source seeing
// ch_ready[k]=0 holds its tag/data until accepted. The CDB side has no back-pressure.
interface cdb_arbiter_n_if #(
    parameter int NUM_CH = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int SRC_W = $clog2(NUM_CH);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*TAG_W-1:0]  ch_tag;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_branch;
    logic [NUM_CH-1:0]        ch_branch_taken;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     flush;

    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic                     cdb_branch;
    logic                     cdb_branch_taken;
    logic [SRC_W-1:0]         cdb_src;

    logic [NUM_CH*CW-1:0]     dbg_count;
    logic [SRC_W-1:0]         dbg_rr_ptr;

    modport slave (
        input  ch_valid, ch_tag, ch_data, ch_branch, ch_branch_taken, flush,
        output ch_ready, cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken,
               cdb_src, dbg_count, dbg_rr_ptr
    );

    modport master (
        output ch_valid, ch_tag, ch_data, ch_branch, ch_branch_taken, flush,
        input  ch_ready, cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken,
               cdb_src, dbg_count, dbg_rr_ptr
    );

endinterface

// File: rtl/cdb_chan_fifo.sv
// Per-channel submit queue: DEPTH-entry synchronous FIFO with flush.
// Flush clears the queue and overrides any push or pop in the same cycle.
module cdb_chan_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 40
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            // Push and pop together leave the count unchanged.
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter_n.sv
// Common-data-bus arbiter: NUM_CH submit queues, one registered broadcast per cycle,
// round-robin or fixed-priority grant, and a mispredict flush of all queued results.
module cdb_arbiter_n
    import cdb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 2,
    parameter int TAG_W    = CDB_TAG_W,
    parameter int DATA_W   = CDB_DATA_W,
    parameter int ARB_MODE = ARB_RR
) (
    input logic            i_clk,
    input logic            i_rst,
    cdb_arbiter_n_if.slave bus
);

    localparam int SRC_W   = $clog2(NUM_CH);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = TAG_W + DATA_W + 2;

    // Same field layout as cdb_entry_t, at the configured widths.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              branch;
        logic              branch_taken;
    } entry_t;

    entry_t            in_ent [NUM_CH];
    entry_t            head   [NUM_CH];
    logic [CW-1:0]     count  [NUM_CH];
    logic [NUM_CH-1:0] push, pop, full, empty;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        assign in_ent[k] = {bus.ch_tag[k*TAG_W +: TAG_W], bus.ch_data[k*DATA_W +: DATA_W],
                            bus.ch_branch[k], bus.ch_branch_taken[k]};
        assign push[k]   = bus.ch_valid[k] & ~full[k];

        cdb_chan_fifo #(
            .DEPTH(DEPTH),
            .WIDTH(ENTRY_W)
        ) u_fifo (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .flush (bus.flush),
            .wdata (in_ent[k]),
            .rdata (head[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .count (count[k])
        );

        assign bus.dbg_count[k*CW +: CW] = count[k];
    end

    assign bus.ch_ready = ~full;

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    entry_t            cdb_ent_q, cdb_ent_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [NUM_CH-1:0] req, req_rot;
    logic [SRC_W-1:0]  base, off, grant_idx;
    logic              grant_valid;
    entry_t            grant_ent;

    assign req  = ~empty;
    assign base = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_q;

    // Rotate requests so 'base' sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        req_rot     = '0;
        off         = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_rot[i] = req[wrap_add(i, 32'(base), NUM_CH)];
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off         = SRC_W'(i);
                grant_valid = 1'b1;
            end
        end
        grant_idx = SRC_W'(wrap_add(32'(off), 32'(base), NUM_CH));
    end

    always_comb begin
        pop       = '0;
        grant_ent = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_valid && (SRC_W'(k) == grant_idx)) begin
                pop[k]    = 1'b1;
                grant_ent = head[k];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_ent_d   = cdb_ent_q;
        cdb_src_d   = cdb_src_q;
        if (grant_valid && !bus.flush) begin
            cdb_valid_d = 1'b1;
            cdb_ent_d   = grant_ent;
            cdb_src_d   = grant_idx;
            if (ARB_MODE == ARB_RR) begin
                rr_ptr_d = SRC_W'(wrap_add(32'(grant_idx), 1, NUM_CH));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_ent_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_ent_q   <= cdb_ent_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.cdb_valid        = cdb_valid_q;
    assign bus.cdb_tag          = cdb_ent_q.tag;
    assign bus.cdb_data         = cdb_ent_q.data;
    assign bus.cdb_branch       = cdb_ent_q.branch;
    assign bus.cdb_branch_taken = cdb_ent_q.branch_taken;
    assign bus.cdb_src          = cdb_src_q;
    assign bus.dbg_rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter_n.sv
// Bench for cdb_arbiter_n: a round-robin and a fixed-priority instance share one
// stimulus stream and are compared every cycle against a queue-based reference model.
module tb_cdb_arbiter_n;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int CW = 2;

    // ---------------- clock / reset ----------------
    logic clk, rst, flush_i;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    v, br, tk;
    logic [TW-1:0]   tg [N];
    logic [DW-1:0]   dt [N];
    logic [N*TW-1:0] tag_p;
    logic [N*DW-1:0] data_p;

    always_comb begin
        tag_p  = '0;
        data_p = '0;
        for (int k = 0; k < N; k++) begin
            tag_p[k*TW +: TW]  = tg[k];
            data_p[k*DW +: DW] = dt[k];
        end
    end

    cdb_arbiter_n_if #(.NUM_CH(N), .TAG_W(TW), .DATA_W(DW), .DEPTH(D)) bus_rr ();
    cdb_arbiter_n_if #(.NUM_CH(N), .TAG_W(TW), .DATA_W(DW), .DEPTH(D)) bus_fp ();

    assign bus_rr.ch_valid = v;
    assign bus_rr.ch_tag = tag_p;
    assign bus_rr.ch_data = data_p;
    assign bus_rr.ch_branch = br;
    assign bus_rr.ch_branch_taken = tk;
    assign bus_rr.flush = flush_i;
    assign bus_fp.ch_valid = v;
    assign bus_fp.ch_tag = tag_p;
    assign bus_fp.ch_data = data_p;
    assign bus_fp.ch_branch = br;
    assign bus_fp.ch_branch_taken = tk;
    assign bus_fp.flush = flush_i;

    cdb_arbiter_n #(.NUM_CH(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW), .ARB_MODE(0)) dut_rr (
        .i_clk(clk), .i_rst(rst), .bus(bus_rr));
    cdb_arbiter_n #(.NUM_CH(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW), .ARB_MODE(1)) dut_fp (
        .i_clk(clk), .i_rst(rst), .bus(bus_fp));

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [TW-1:0] exp_q[$];

    cdb_entry_t mq [2*N][$];
    logic       m_valid [2];
    cdb_entry_t m_ent   [2];
    int         m_src   [2];
    int         m_rr    [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model of one rising edge, m=0 round-robin, m=1 fixed priority.
    task automatic model_edge();
        int sz [N];
        int g, start, ch;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int k = 0; k < N; k++) mq[m*N+k].delete();
                m_rr[m] = 0; m_valid[m] = 1'b0; m_ent[m] = '0; m_src[m] = 0;
            end else if (flush_i) begin
                for (int k = 0; k < N; k++) mq[m*N+k].delete();
                m_valid[m] = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) sz[k] = mq[m*N+k].size();
                start = (m == 0) ? m_rr[m] : 0;
                g = -1;
                for (int i = 0; i < N; i++) begin
                    ch = (start + i) % N;
                    if (g < 0 && sz[ch] > 0) g = ch;
                end
                if (g >= 0) begin
                    m_ent[m] = mq[m*N+g].pop_front();
                    m_valid[m] = 1'b1;
                    m_src[m] = g;
                    if (m == 0) m_rr[m] = (g + 1) % N;
                end else begin
                    m_valid[m] = 1'b0;
                end
                for (int k = 0; k < N; k++) begin
                    if (v[k] && sz[k] < D)
                        mq[m*N+k].push_back('{tag: tg[k], data: dt[k], branch: br[k],
                                              branch_taken: tk[k]});
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_vec(input int m);
        logic [N-1:0] rdy;
        for (int k = 0; k < N; k++) rdy[k] = (mq[m*N+k].size() != D);
        return {15'b0, m_valid[m], 2'(m_src[m]), m_ent[m].tag, m_ent[m].data,
                m_ent[m].branch, m_ent[m].branch_taken, rdy, 2'(m_rr[m])};
    endfunction

    task automatic check_model();
        chk("model_rr", {15'b0, bus_rr.cdb_valid, bus_rr.cdb_src, bus_rr.cdb_tag, bus_rr.cdb_data,
                         bus_rr.cdb_branch, bus_rr.cdb_branch_taken, bus_rr.ch_ready,
                         bus_rr.dbg_rr_ptr}, exp_vec(0));
        chk("model_fp", {15'b0, bus_fp.cdb_valid, bus_fp.cdb_src, bus_fp.cdb_tag, bus_fp.cdb_data,
                         bus_fp.cdb_branch, bus_fp.cdb_branch_taken, bus_fp.ch_ready,
                         bus_fp.dbg_rr_ptr}, exp_vec(1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        v = '0; br = '0; tk = '0; flush_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            tg[k] = '0;
            dt[k] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [TW-1:0] t);
        v[k] = 1'b1;
        tg[k] = t;
        dt[k] = 32'hA000_0000 | 32'(t);
    endtask

    typedef struct {
        logic [N-1:0]    v;
        logic [N*TW-1:0] tags;
        logic            ev;
        logic [TW-1:0]   et;
        logic [SW-1:0]   es;
    } vec_t;
    vec_t tbl [10];

    initial begin
        tbl[0] = '{v: 4'hF, tags: {6'd4, 6'd3, 6'd2, 6'd1}, ev: 1'b0, et: 6'd0, es: 2'd0};
        tbl[1] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd1, es: 2'd0};
        tbl[2] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd2, es: 2'd1};
        tbl[3] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd3, es: 2'd2};
        tbl[4] = '{v: 4'hF, tags: {6'd8, 6'd7, 6'd6, 6'd5}, ev: 1'b1, et: 6'd4, es: 2'd3};
        tbl[5] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd5, es: 2'd0};
        tbl[6] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd6, es: 2'd1};
        tbl[7] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd7, es: 2'd2};
        tbl[8] = '{v: 4'h0, tags: '0, ev: 1'b1, et: 6'd8, es: 2'd3};
        tbl[9] = '{v: 4'h0, tags: '0, ev: 1'b0, et: 6'd8, es: 2'd3};

        do_reset();

        // Idle after reset: everything zero, all channels ready.
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_rr", {bus_rr.ch_ready, bus_rr.cdb_valid, bus_rr.cdb_tag, bus_rr.cdb_data,
                            bus_rr.cdb_branch, bus_rr.cdb_branch_taken, bus_rr.cdb_src},
                {4'hF, 43'b0});
            chk("idle_fp", {bus_fp.ch_ready, bus_fp.cdb_valid, bus_fp.cdb_tag, bus_fp.cdb_data,
                            bus_fp.cdb_branch, bus_fp.cdb_branch_taken, bus_fp.cdb_src},
                {4'hF, 43'b0});
        end

        // Single push on ch2: visible two edges later for exactly one cycle.
        v[2] = 1'b1; tg[2] = 6'h15; dt[2] = 32'hDEADBEEF; br[2] = 1'b1; tk[2] = 1'b1;
        step();
        chk("single_early", bus_rr.cdb_valid, 1'b0);
        idle_inputs();
        step();
        chk("single_rr", {bus_rr.cdb_valid, bus_rr.cdb_tag, bus_rr.cdb_data, bus_rr.cdb_branch,
                          bus_rr.cdb_branch_taken, bus_rr.cdb_src},
            {1'b1, 6'h15, 32'hDEADBEEF, 1'b1, 1'b1, 2'd2});
        chk("single_fp", {bus_fp.cdb_valid, bus_fp.cdb_tag, bus_fp.cdb_data, bus_fp.cdb_branch,
                          bus_fp.cdb_branch_taken, bus_fp.cdb_src},
            {1'b1, 6'h15, 32'hDEADBEEF, 1'b1, 1'b1, 2'd2});
        step();
        chk("single_once", {bus_rr.cdb_valid, bus_fp.cdb_valid}, 2'b00);

        // Round-robin waves from the vector table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            for (int k = 0; k < N; k++) begin
                if (tbl[i].v[k]) set_ch(k, tbl[i].tags[k*TW +: TW]);
            end
            step();
            chk($sformatf("wave%0d_valid", i), bus_rr.cdb_valid, tbl[i].ev);
            chk($sformatf("wave%0d_tag", i), bus_rr.cdb_tag, tbl[i].et);
            chk($sformatf("wave%0d_src", i), bus_rr.cdb_src, tbl[i].es);
        end

        // ch0 streaming at one result per cycle with valid held high.
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            if (c < 8) begin
                chk("stream_ready", bus_rr.ch_ready[0], 1'b1);
                set_ch(0, TW'(6'h20 + c));
                exp_q.push_back(TW'(6'h20 + c));
            end
            step();
            if (c >= 1 && c <= 8) begin
                chk("stream_valid", bus_rr.cdb_valid, 1'b1);
                if (exp_q.size() > 0) chk("stream_tag", bus_rr.cdb_tag, exp_q.pop_front());
            end
        end
        chk("stream_drain", exp_q.size(), 0);

        // Fixed priority: ch0 drains before ch3, ch3 blocked while holding two entries.
        do_reset();
        exp_q.delete();
        exp_q = '{6'h10, 6'h11, 6'h12, 6'h30, 6'h31};
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            if (c == 0) begin set_ch(0, 6'h10); set_ch(3, 6'h30); end
            if (c == 1) begin set_ch(0, 6'h11); set_ch(3, 6'h31); end
            if (c == 2) set_ch(0, 6'h12);
            step();
            chk("prio_valid", bus_fp.cdb_valid, (c >= 1 && c <= 5));
            if (bus_fp.cdb_valid && exp_q.size() > 0)
                chk("prio_tag", bus_fp.cdb_tag, exp_q.pop_front());
            chk("prio_ready3", bus_fp.ch_ready[3], !(c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) chk("prio_count3", bus_fp.dbg_count[3*CW +: CW], 2'd2);
        end

        // Flush with five queued results and a concurrent push on ch1.
        do_reset();
        idle_inputs();
        for (int k = 0; k < N; k++) set_ch(k, TW'(6'h31 + k));
        step();
        idle_inputs();
        set_ch(0, 6'h35);
        set_ch(2, 6'h36);
        step();
        chk("flush_prev", {bus_rr.cdb_valid, bus_rr.cdb_tag}, {1'b1, 6'h31});
        idle_inputs();
        flush_i = 1'b1;
        set_ch(1, 6'h37);
        step();
        idle_inputs();
        chk("flush_ready", {bus_rr.ch_ready, bus_fp.ch_ready}, 8'hFF);
        chk("flush_count", {bus_rr.dbg_count, bus_fp.dbg_count}, 16'h0);
        for (int c = 0; c < 6; c++) begin
            chk("flush_quiet", {bus_rr.cdb_valid, bus_fp.cdb_valid}, 2'b00);
            step();
        end

        // Reset and flush together in mid-operation.
        idle_inputs();
        for (int k = 0; k < N; k++) set_ch(k, TW'(6'h01 + k));
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        flush_i = 1'b1;
        step();
        chk("rstflush_rr", {bus_rr.ch_ready, bus_rr.cdb_valid, bus_rr.cdb_tag, bus_rr.cdb_data,
                            bus_rr.cdb_src, bus_rr.dbg_rr_ptr}, {4'hF, 43'b0});
        rst = 1'b0;
        flush_i = 1'b0;
        step();
        chk("rstflush_quiet", {bus_rr.cdb_valid, bus_fp.cdb_valid}, 2'b00);

        // Randomised traffic with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                v[k]  = 1'($urandom_range(0, 1));
                tg[k] = TW'($urandom_range(0, 63));
                dt[k] = $urandom;
                br[k] = 1'($urandom_range(0, 1));
                tk[k] = 1'($urandom_range(0, 1));
            end
            flush_i = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter_n.md
Name: cdb_arbiter_n

Overview:
Parametrised common-data-bus arbiter for the out-of-order RISC-V core. It sits between NUM_CH execution-unit submit ports (int, mult, div, mem, and any added units) and the single CDB that feeds the dispatcher's tag matching.
- Each channel has a small submit queue.
- Exactly one queued result is granted per cycle, under round-robin or fixed-priority arbitration.
- A flush input drops all in-flight results on a branch mispredict.

Parameters:
NUM_CH, 4, number of execution-unit submit channels (2..8)
DEPTH, 2, entries per channel queue (power of 2, >=2)
TAG_W, 6, ROB/register tag width
DATA_W, 32, result data width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous active-high reset
ch_valid  in  NUM_CH  per-channel submit request
ch_tag  in  NUM_CH*TAG_W  per-channel result tag (channel k at bits [k*TAG_W +: TAG_W])
ch_data  in  NUM_CH*DATA_W  per-channel result data
ch_branch  in  NUM_CH  result is a branch resolution
ch_branch_taken  in  NUM_CH  branch outcome
ch_ready  out  NUM_CH  channel queue can accept (issue_done back to the issue logic)
flush  in  1  mispredict flush; discard all queued and pending results
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_W  broadcast tag
cdb_data  out  DATA_W  broadcast data
cdb_branch  out  1  broadcast is a branch
cdb_branch_taken  out  1  branch taken
cdb_src  out  $clog2(NUM_CH)  index of the granted channel

Behaviour:
- Reset (i_rst=1 at an edge):
  - all queues empty, count=0, read/write pointers 0
  - RR pointer = 0
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_branch=0, cdb_branch_taken=0, cdb_src=0
  - ch_ready = all 1s on the cycle after reset is released
  - reset mid-operation discards all content with no broadcast
- Accept: a channel push occurs when ch_valid[k] && ch_ready[k].
  - ch_ready[k] = (count_k != DEPTH); it is registered state only and does not depend on ch_valid.
  - ch_valid while ch_ready=0 is ignored; the source holds the value.
- Grant: computed combinationally from non-empty queue heads each cycle; at most one grant per cycle.
  - ARB_MODE=0: search starts at the RR pointer, wrapping modulo NUM_CH. On a grant to channel g, the RR pointer becomes (g+1) mod NUM_CH. The pointer is unchanged when there is no grant.
  - ARB_MODE=1: lowest-index non-empty channel wins; the RR pointer is unused.
- CDB output is registered.
  - The granted head is popped and appears on the cdb_* outputs on the next cycle.
  - With no grant, cdb_valid=0 and the other cdb_* fields hold their last values.
- Latency: a result accepted at edge t (queue previously empty and channel granted) gives cdb_valid=1 in the cycle after edge t+1, i.e. 2 cycles.
- Throughput: 1 result/cycle aggregate. A single channel can sustain 1/cycle if DEPTH>=2.
- Simultaneous push and pop on the same queue in one cycle: count unchanged and data order preserved. Push into a queue at count DEPTH-1 is allowed while that queue is also popped.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Count is DEPTH-width+1 bits, so full and empty are distinguishable.
- Flush (synchronous, takes priority over push and pop):
  - all queues cleared
  - pushes presented in the same cycle dropped
  - cdb_valid=0 next cycle
  - RR pointer unchanged
  - a broadcast already on the CDB in the flush cycle remains visible for that cycle only
- Simultaneous i_rst and flush: reset wins (identical effect, plus RR pointer=0).
- Fixed-priority starvation of high-index channels in ARB_MODE=1 is accepted by design; no aging.

Decomposition:
- Package cdb_pkg:
  - typedef cdb_entry_t (tag, data, branch, branch_taken) parametrised via TAG_W/DATA_W localparams
  - ARB_RR / ARB_FIXED constants
  - existing cdb_submit_data migrates to wrap cdb_entry_t
- Sub-module cdb_chan_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, full, empty and count, instantiated NUM_CH times via generate.
- Arbitration logic stays in cdb_arbiter_n as a rotate-priority-encode-unrotate scheme.

Test Plan:
- Reset, then idle → ch_ready=4'b1111, cdb_valid=0 for 10 cycles; all cdb_* outputs are 0.
- Single push ch2 (tag=6'h15, data=32'hDEADBEEF, branch=1, taken=1) at edge t → cdb_valid=1 with tag 6'h15, data DEADBEEF, branch=1, taken=1, cdb_src=2 two cycles after t, for exactly one cycle.
- ARB_MODE=0, all 4 channels push one entry in the same cycle (tags 1,2,3,4) → CDB tags 1,2,3,4 on consecutive cycles, cdb_src 0,1,2,3. A second simultaneous wave of 4 pushes (tags 5..8) issued while the last of wave 1 is granted → tags 5..8 in src order 0,1,2,3, since the RR pointer wraps to 0.
- Fill ch0 with DEPTH=2 entries while its grants are blocked by ARB_MODE=1 pressure from no one (only ch0 active, cdb pops each cycle) → with ch_valid held high continuously, ch_ready[0] never drops; 8 back-to-back tags appear in order with no gaps after the 2-cycle fill.
- ARB_MODE=1, ch3 and ch0 both hold 2 entries → both ch0 entries broadcast before any ch3 entry; ch_ready[3]=0 while ch3 count=2.
- Queues loaded with 5 entries across channels, assert flush for 1 cycle with a concurrent push on ch1 → cdb_valid=0 from the cycle after flush, no flushed or dropped tag ever broadcast, all ch_ready=1 one cycle after flush.
